// File: rtl/fetch_align.sv
// fetch_align: aligns RV32/RV16 instructions out of the last fetched 64-bit
// isram line. The line arriving this cycle is bypassed straight to the output.
// A 32-bit instruction that straddles two lines has its low halfword parked in
// lo_q while the PC is held until the following line shows up.
// Optional build macro: FETCH_ILLEGAL_CHK_EN enables the fetch_illegal
// check on the aligned instruction. When the macro is undefined,
// fetch_illegal is tied low.
module fetch_align #(
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int          MISS_LIMIT = 15
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic [63:0] isram_rdata,
  input  logic        isram_cs_ff,
  input  logic [28:0] isram_adr_ff,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        fet_stall,
  output logic [31:0] rv32_instr,
  output logic        isrv16,
  output logic        instr_valid,
  output logic        fetch_misalign,
  output logic        fetch_refetch,
  output logic        fetch_illegal
);

  typedef enum logic [1:0] {EMPTY = 2'd0, RUN = 2'd1, CROSS = 2'd2} state_e;

  localparam logic [7:0] LIM_M1 = 8'(MISS_LIMIT - 1);

  state_e      state_q, state_d;
  logic [63:0] line_q;
  logic [28:0] tag_q;
  logic        vld_q;
  logic [15:0] lo_q, lo_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;

  // pc[0] carries no information for halfword-aligned fetch
  logic unused_pc0;
  assign unused_pc0 = pc[0];

  // Current line: the arriving isram data wins over the buffered copy
  logic [63:0] cur_line;
  logic [28:0] cur_tag;
  logic        cur_vld;
  assign cur_line = isram_cs_ff ? isram_rdata  : line_q;
  assign cur_tag  = isram_cs_ff ? isram_adr_ff : tag_q;
  assign cur_vld  = isram_cs_ff | vld_q;

  logic [1:0]  idx, idx_n;
  logic [28:0] pc_tag, nxt_tag;
  logic [15:0] lo, hi;
  logic        hit, xhit;
  assign idx     = pc[2:1];
  assign idx_n   = idx + 2'd1;
  assign pc_tag  = pc[31:3];
  assign nxt_tag = pc_tag + 29'd1;      // wraps from all-ones to zero
  assign lo      = cur_line[{idx, 4'b0} +: 16];
  assign hi      = cur_line[{idx_n, 4'b0} +: 16];
  assign hit     = cur_vld && (cur_tag == pc_tag);
  assign xhit    = cur_vld && (cur_tag == nxt_tag);

  logic [31:0] instr_c;
  logic        valid_c, misalign_c, refetch_c, miss_c;

  // Next state, straddle/miss bookkeeping and instruction selection
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    miss_cnt_d = miss_cnt_q;
    instr_c    = NOP_INSTR;
    valid_c    = 1'b0;
    misalign_c = 1'b0;
    refetch_c  = 1'b0;
    miss_c     = 1'b0;
    if (flush) begin
      // Redirect: any parked halfword belongs to the old stream
      state_d    = vld_q ? RUN : EMPTY;
      lo_d       = 16'h0;
      miss_cnt_d = 8'h0;
    end else begin
      unique case (state_q)
        EMPTY, RUN: begin
          if (hit) begin
            state_d = RUN;
            if (lo[1:0] != 2'b11) begin
              valid_c = 1'b1;
              instr_c = {16'h0, lo};
            end else if (idx != 2'b11) begin
              valid_c = 1'b1;
              instr_c = {hi, lo};
            end else begin
              misalign_c = 1'b1;
              lo_d       = lo;
              state_d    = CROSS;
            end
          end else begin
            miss_c = 1'b1;
          end
        end
        CROSS: begin
          if (xhit) begin
            valid_c = 1'b1;
            instr_c = {cur_line[15:0], lo_q};
            state_d = RUN;
          end else begin
            miss_c = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (miss_c) begin
        misalign_c = 1'b1;
        if (miss_cnt_q == LIM_M1) begin
          refetch_c  = 1'b1;
          miss_cnt_d = 8'h0;
        end else begin
          miss_cnt_d = miss_cnt_q + 8'd1;
        end
      end
      if (valid_c) miss_cnt_d = 8'h0;
      // Stall freezes state; refetch is suppressed so it stays a single pulse
      if (fet_stall) begin
        state_d    = state_q;
        lo_d       = lo_q;
        miss_cnt_d = miss_cnt_q;
        refetch_c  = 1'b0;
      end
    end
  end

  // FSM, parked halfword and miss counter
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      state_q    <= EMPTY;
      lo_q       <= 16'h0;
      miss_cnt_q <= 8'h0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Line buffer captures every unstalled isram return, flush or not
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      line_q <= 64'h0;
      tag_q  <= 29'h0;
      vld_q  <= 1'b0;
    end else if (isram_cs_ff && !fet_stall) begin
      line_q <= isram_rdata;
      tag_q  <= isram_adr_ff;
      vld_q  <= 1'b1;
    end
  end

  // Outputs are forced to idle values while reset is held
  always_comb begin
    rv32_instr     = cpurst ? NOP_INSTR : instr_c;
    instr_valid    = !cpurst && valid_c;
    isrv16         = !cpurst && valid_c && (instr_c[1:0] != 2'b11);
    fetch_misalign = !cpurst && misalign_c;
    fetch_refetch  = !cpurst && refetch_c;
  end

`ifdef FETCH_ILLEGAL_CHK_EN
  // All-zero word, all-zero compressed halfword, or all-ones 32-bit word
  always_comb begin
    fetch_illegal = instr_valid &&
                    ((rv32_instr == 32'h0) ||
                     ((rv32_instr[1:0] != 2'b11) && (rv32_instr[15:0] == 16'h0)) ||
                     ((rv32_instr[1:0] == 2'b11) && (rv32_instr == 32'hFFFF_FFFF)));
  end
`else
  assign fetch_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: the driver computes expected outputs from a
// line/straddle reference model and queues them; a negedge monitor compares.
module tb_fetch_align;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          LIMIT = 15;

  logic        clk = 1'b0;
  logic        cpurst;
  logic [63:0] isram_rdata;
  logic        isram_cs_ff;
  logic [28:0] isram_adr_ff;
  logic [31:0] pc;
  logic        flush, fet_stall;
  logic [31:0] rv32_instr;
  logic        isrv16, instr_valid, fetch_misalign, fetch_refetch, fetch_illegal;

  always #5 clk = ~clk;

  fetch_align #(.NOP_INSTR(NOP), .MISS_LIMIT(LIMIT)) dut (
    .clk(clk), .cpurst(cpurst), .isram_rdata(isram_rdata), .isram_cs_ff(isram_cs_ff),
    .isram_adr_ff(isram_adr_ff), .pc(pc), .flush(flush), .fet_stall(fet_stall),
    .rv32_instr(rv32_instr), .isrv16(isrv16), .instr_valid(instr_valid),
    .fetch_misalign(fetch_misalign), .fetch_refetch(fetch_refetch),
    .fetch_illegal(fetch_illegal)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        rv16, valid, mis, refetch, ill;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0, nerr = 0;

  // Reference model state: last line seen, pending straddle half, miss run length
  bit          m_vld;
  logic [63:0] m_line;
  logic [28:0] m_tag;
  bit          m_pend;
  logic [15:0] m_lo;
  int          m_cnt;

  function automatic logic [15:0] hw(input logic [63:0] l, input int k);
    return l[16*k +: 16];
  endfunction

  task automatic step(input bit rst, input bit cs, input logic [63:0] rd,
                      input logic [28:0] adr, input logic [31:0] p,
                      input bit fl, input bit st);
    exp_t        e;
    bit          cv, v, miss;
    logic [63:0] cl;
    logic [28:0] ct, pt;
    logic [15:0] lo;
    logic [31:0] ins;
    int          k;
    @(posedge clk);
    #1;
    cpurst = rst; isram_cs_ff = cs; isram_rdata = rd; isram_adr_ff = adr;
    pc = p; flush = fl; fet_stall = st;
    e = '0;
    e.instr = NOP;
    if (rst) begin
      m_vld = 0; m_line = '0; m_tag = '0; m_pend = 0; m_lo = '0; m_cnt = 0;
      q.push_back(e);
      return;
    end
    cv = cs || m_vld;
    cl = cs ? rd : m_line;
    ct = cs ? adr : m_tag;
    pt = p[31:3];
    k  = int'(p[2:1]);
    v = 0; miss = 0; ins = NOP;
    if (fl) begin
      m_pend = 0; m_lo = '0; m_cnt = 0;
    end else begin
      if (m_pend) begin
        if (cv && ct == pt + 29'd1) begin
          v = 1; ins = {cl[15:0], m_lo};
          if (!st) m_pend = 0;
        end else miss = 1;
      end else if (cv && ct == pt) begin
        lo = hw(cl, k);
        if (lo[1:0] != 2'b11) begin v = 1; ins = {16'h0, lo}; end
        else if (k != 3) begin v = 1; ins = {hw(cl, k + 1), lo}; end
        else begin
          e.mis = 1;
          if (!st) begin m_pend = 1; m_lo = lo; end
        end
      end else miss = 1;
      if (v && !st) m_cnt = 0;
      if (miss) begin
        e.mis = 1;
        if (!st) begin
          if (m_cnt == LIMIT - 1) begin e.refetch = 1; m_cnt = 0; end
          else m_cnt++;
        end
      end
    end
    if (cs && !st) begin m_line = rd; m_tag = adr; m_vld = 1; end
    e.valid = v;
    e.instr = ins;
    e.rv16  = v && (ins[1:0] != 2'b11);
`ifdef FETCH_ILLEGAL_CHK_EN
    e.ill   = v && (ins == 32'h0 || ins == 32'hFFFF_FFFF);
`endif
    q.push_back(e);
  endtask

  // Monitor: one expected entry per presented cycle
  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {rv32_instr, isrv16, instr_valid, fetch_misalign, fetch_refetch, fetch_illegal};
      ncmp++;
      if (g !== e) begin
        nerr++;
        $display("FAIL outputs t=%0t pc=%h: got instr=%h rv16=%b vld=%b mis=%b ref=%b ill=%b, want instr=%h rv16=%b vld=%b mis=%b ref=%b ill=%b",
                 $time, pc, g.instr, g.rv16, g.valid, g.mis, g.refetch, g.ill,
                 e.instr, e.rv16, e.valid, e.mis, e.refetch, e.ill);
      end
    end
  end

  localparam logic [63:0] L1 = 64'h0593_0513_4505_0093;
  localparam logic [63:0] L2 = 64'hAB03_1234_5677_0010;

  initial begin
    logic [28:0] a;
    logic [63:0] d;
    cpurst = 1'b1; isram_cs_ff = 0; isram_rdata = '0; isram_adr_ff = '0;
    pc = '0; flush = 0; fet_stall = 0;
    step(1, 0, '0, '0, 32'h0, 0, 0);
    step(1, 0, '0, '0, 32'h0, 0, 0);
    // Aligned fetches from one line, then a straddle into the next line
    step(0, 1, L1, 29'h20, 32'h100, 0, 0);
    step(0, 0, '0, '0, 32'h102, 0, 0);
    step(0, 0, '0, '0, 32'h104, 0, 0);
    step(0, 0, '0, '0, 32'h106, 0, 0);
    step(0, 0, '0, '0, 32'h106, 0, 0);
    step(0, 1, L2, 29'h21, 32'h106, 0, 0);
    step(0, 0, '0, '0, 32'h10A, 0, 0);
    // Reset while a straddle is parked, then a clean reload
    step(0, 0, '0, '0, 32'h10E, 0, 0);
    step(1, 0, '0, '0, 32'h10E, 0, 0);
    step(0, 1, L1, 29'h20, 32'h100, 0, 0);
    // Flush during straddle; the line arriving with flush still loads
    step(0, 0, '0, '0, 32'h106, 0, 0);
    step(0, 1, L2, 29'h21, 32'h106, 1, 0);
    step(0, 0, '0, '0, 32'h108, 0, 0);
    // Persistent miss: refetch pulse after LIMIT cycles
    for (int i = 0; i < LIMIT + 3; i++) step(0, 0, '0, '0, 32'h200, 0, 0);
    // All-zero word and a stalled fetch
    step(0, 1, 64'h1111_2223_0000_0000, 29'h40, 32'h200, 0, 0);
    step(0, 0, '0, '0, 32'h204, 0, 1);
    step(0, 0, '0, '0, 32'h204, 0, 0);
    // Straddle across the top of the address space
    step(0, 1, 64'h0003_5555_6666_7777, 29'h1FFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    step(0, 1, 64'h9999_8888_7777_1234, 29'h0, 32'hFFFF_FFFE, 0, 0);
    step(0, 0, '0, '0, 32'h0, 1, 0);
    // Randomized traffic over a small window of lines
    for (int i = 0; i < 3000; i++) begin
      a = 29'h20 + 29'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) d[31:0] = 32'h0;
      if ($urandom_range(0, 15) == 0) d[63:32] = 32'hFFFF_FFFF;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, d, a,
           {29'h20 + 29'($urandom_range(0, 3)), 3'($urandom_range(0, 7))},
           $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
    end
    step(0, 0, '0, '0, 32'h0, 1, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
